// File: rtl/m32b_8b.sv
// m32b_8b: 32-bit word to 8-bit byte-stream width converter with a one-word
// holding buffer, so a continuous word stream is emitted without bubbles.
module m32b_8b #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        first_byte_out
);

    localparam int unsigned W_WORD = 32;
    localparam int unsigned W_BYTE = 8;
    localparam int unsigned W_CNT  = 2;
    localparam logic [W_CNT-1:0] LAST_IDX = W_CNT'(3);

    logic [W_WORD-1:0] sr_q, sr_d;
    logic [W_WORD-1:0] hold_q, hold_d;
    logic [W_CNT-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              hold_valid_q, hold_valid_d;

    logic              accept;
    logic              xfer;
    logic              sr_free;
    logic [W_CNT-1:0]  byte_sel;

    // State registers; reset discards any partial word and the held word
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            sr_q         <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Handshakes: the shift word frees when idle or on its last byte transfer
    always_comb begin
        accept  = valid_in & ready_out;
        xfer    = busy_q & ready_in;
        sr_free = ~busy_q | (xfer & (cnt_q == LAST_IDX));
    end

    // Next-state: advance byte index, refill shift word, park a word in HOLD
    always_comb begin
        sr_d         = sr_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        hold_valid_d = hold_valid_q;

        if (xfer && (cnt_q != LAST_IDX)) begin
            cnt_d = cnt_q + W_CNT'(1);
        end

        if (sr_free) begin
            if (hold_valid_q) begin
                // HOLD has priority so word order is preserved
                sr_d         = hold_q;
                hold_valid_d = 1'b0;
                cnt_d        = '0;
                busy_d       = 1'b1;
            end else if (accept) begin
                sr_d   = data_in;
                cnt_d  = '0;
                busy_d = 1'b1;
            end else begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end
        end else if (accept) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end
    end

    // Output decode from registers only; byte order set by MSB_FIRST
    always_comb begin
        ready_out      = reset_L & ~hold_valid_q;
        valid_out      = busy_q;
        first_byte_out = busy_q & (cnt_q == '0);
        byte_sel       = MSB_FIRST ? (LAST_IDX - cnt_q) : cnt_q;
        data_out       = '0;
        if (busy_q) begin
            case (byte_sel)
                2'd0:    data_out = sr_q[7:0];
                2'd1:    data_out = sr_q[15:8];
                2'd2:    data_out = sr_q[23:16];
                default: data_out = sr_q[31:24];
            endcase
        end
    end

endmodule

// File: tb/tb_m32b_8b.sv
// Bench for m32b_8b: both byte orders run side by side against a word-queue model.
module tb_m32b_8b;

    logic        clk_4f;
    logic        reset_L;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_in;

    logic        m_ready_out, m_valid_out, m_first;
    logic [7:0]  m_data_out;
    logic        l_ready_out, l_valid_out, l_first;
    logic [7:0]  l_data_out;

    int vectors;
    int miscompares;

    // Model: queue of words owned by the converter (shifting + held) and byte index of the head
    logic [31:0] mq[$];
    int          midx;

    logic [7:0]  got[$];

    m32b_8b #(.MSB_FIRST(1'b1)) u_msb (
        .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .ready_out(m_ready_out), .data_out(m_data_out), .valid_out(m_valid_out),
        .ready_in(ready_in), .first_byte_out(m_first)
    );

    m32b_8b #(.MSB_FIRST(1'b0)) u_lsb (
        .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .ready_out(l_ready_out), .data_out(l_data_out), .valid_out(l_valid_out),
        .ready_in(ready_in), .first_byte_out(l_first)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input bit msb);
        logic [31:0] w;
        int          sel;
        if (mq.size() == 0) return 8'h00;
        w   = mq[0];
        sel = msb ? (3 - midx) : midx;
        return w[8*sel +: 8];
    endfunction

    // Model update: at most two words inside; a word leaves after its fourth byte transfer
    initial begin
        midx = 0;
        forever begin
            @(posedge clk_4f or negedge reset_L);
            if (!reset_L) begin
                mq.delete();
                midx = 0;
            end else if (clk_4f) begin
                bit acc;
                bit xf;
                acc = valid_in && (mq.size() < 2);
                xf  = (mq.size() > 0) && ready_in;
                if (xf) begin
                    midx++;
                    if (midx == 4) begin
                        void'(mq.pop_front());
                        midx = 0;
                    end
                end
                if (acc) mq.push_back(data_in);
            end
        end
    end

    // Per-cycle compare of both instances against the model
    initial begin
        forever begin
            @(negedge clk_4f);
            chk("msb_valid", 32'(m_valid_out), 32'(mq.size() > 0));
            chk("msb_data",  32'(m_data_out),  32'(exp_byte(1'b1)));
            chk("msb_first", 32'(m_first),     32'((mq.size() > 0) && (midx == 0)));
            chk("msb_ready", 32'(m_ready_out), 32'(reset_L && (mq.size() < 2)));
            chk("lsb_valid", 32'(l_valid_out), 32'(mq.size() > 0));
            chk("lsb_data",  32'(l_data_out),  32'(exp_byte(1'b0)));
            chk("lsb_first", 32'(l_first),     32'((mq.size() > 0) && (midx == 0)));
            chk("lsb_ready", 32'(l_ready_out), 32'(reset_L && (mq.size() < 2)));
        end
    end

    // Log every byte transferred out of the MSB-first instance
    initial begin
        forever begin
            @(posedge clk_4f);
            if (reset_L && m_valid_out && ready_in) got.push_back(m_data_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    // Check one displayed byte at mid-cycle, then move to the next cycle
    task automatic exp_out(input string name, input logic [7:0] m, input logic [7:0] l, input logic f);
        @(negedge clk_4f);
        chk({name, "_m"}, 32'(m_data_out), 32'(m));
        chk({name, "_l"}, 32'(l_data_out), 32'(l));
        chk({name, "_f"}, 32'(m_first), 32'(f));
        step();
    endtask

    task automatic chk_idle(input string name);
        @(negedge clk_4f);
        chk({name, "_v"}, 32'(m_valid_out), 32'd0);
        chk({name, "_d"}, 32'(m_data_out), 32'd0);
        step();
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic send_word(input logic [31:0] w);
        logic r;
        int   n;
        valid_in = 1'b1;
        data_in  = w;
        n = 0;
        do begin
            @(negedge clk_4f);
            r = m_ready_out;
            step();
            n++;
        end while (!r && n < 20);
        chk("send_accept", 32'(r), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_valid_out; i++) step();
        chk("drain", 32'(m_valid_out), 32'd0);
    endtask

    task automatic chk_log(input string name, input int start, input logic [7:0] e[12]);
        chk({name, "_count"}, 32'(got.size() - start), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (start + i < got.size()) chk({name, "_byte"}, 32'(got[start + i]), 32'(e[i]));
        end
    endtask

    initial begin
        int start;
        logic [7:0] e2[12];
        logic [7:0] e6[12];
        vectors     = 0;
        miscompares = 0;
        reset_L  = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        data_in  = 32'h0;

        repeat (3) @(posedge clk_4f);
        @(negedge clk_4f);
        chk("rst_valid", 32'(m_valid_out), 32'd0);
        chk("rst_data",  32'(m_data_out), 32'd0);
        chk("rst_ready", 32'(m_ready_out), 32'd0);
        chk("rst_first", 32'(m_first), 32'd0);
        reset_L = 1'b1;
        step();

        // 1: single word, both byte orders
        valid_in = 1'b1;
        data_in  = 32'hA1B2C3D4;
        step();
        valid_in = 1'b0;
        data_in  = 32'hDEADBEEF;
        exp_out("t1_b0", 8'hA1, 8'hD4, 1'b1);
        exp_out("t1_b1", 8'hB2, 8'hC3, 1'b0);
        exp_out("t1_b2", 8'hC3, 8'hB2, 1'b0);
        exp_out("t1_b3", 8'hD4, 8'hA1, 1'b0);
        chk_idle("t1_idle");

        // 2: three back-to-back words
        start = got.size();
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_word(32'h99AABBCC);
        valid_in = 1'b0;
        drain();
        e2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        chk_log("t2", start, e2);

        // 3: backpressure while B2 is shown
        valid_in = 1'b1;
        data_in  = 32'hA1B2C3D4;
        step();
        valid_in = 1'b0;
        exp_out("t3_b0", 8'hA1, 8'hD4, 1'b1);
        ready_in = 1'b0;
        exp_out("t3_hold0", 8'hB2, 8'hC3, 1'b0);
        exp_out("t3_hold1", 8'hB2, 8'hC3, 1'b0);
        exp_out("t3_hold2", 8'hB2, 8'hC3, 1'b0);
        ready_in = 1'b1;
        exp_out("t3_b1", 8'hB2, 8'hC3, 1'b0);
        exp_out("t3_b2", 8'hC3, 8'hB2, 1'b0);
        exp_out("t3_b3", 8'hD4, 8'hA1, 1'b0);
        chk_idle("t3_idle");

        // 5: reset mid-word with HOLD full
        valid_in = 1'b1;
        data_in  = 32'hA1B2C3D4;
        step();
        data_in  = 32'h55667788;
        step();
        valid_in = 1'b0;
        step();
        @(negedge clk_4f);
        chk("t5_pre_data", 32'(m_data_out), 32'hC3);
        chk("t5_pre_ready", 32'(m_ready_out), 32'd0);
        #1;
        reset_L = 1'b0;
        #1;
        chk("t5_async_valid", 32'(m_valid_out), 32'd0);
        chk("t5_async_data",  32'(m_data_out), 32'd0);
        chk("t5_async_lvalid", 32'(l_valid_out), 32'd0);
        chk("t5_async_ready", 32'(m_ready_out), 32'd0);
        @(posedge clk_4f);
        @(negedge clk_4f);
        reset_L = 1'b1;
        step();
        valid_in = 1'b1;
        data_in  = 32'h11223344;
        step();
        valid_in = 1'b0;
        exp_out("t5_b0", 8'h11, 8'h44, 1'b1);
        exp_out("t5_b1", 8'h22, 8'h33, 1'b0);
        exp_out("t5_b2", 8'h33, 8'h22, 1'b0);
        exp_out("t5_b3", 8'h44, 8'h11, 1'b0);
        chk_idle("t5_idle");

        // 6: HOLD full, last byte and new word on the same edge
        start = got.size();
        valid_in = 1'b1;
        data_in  = 32'h01020304;
        step();
        data_in  = 32'h05060708;
        step();
        data_in  = 32'h090A0B0C;
        step();
        step();
        @(negedge clk_4f);
        chk("t6_last_data", 32'(m_data_out), 32'h04);
        chk("t6_last_ready", 32'(m_ready_out), 32'd0);
        step();
        @(negedge clk_4f);
        chk("t6_next_ready", 32'(m_ready_out), 32'd1);
        chk("t6_next_data", 32'(m_data_out), 32'h05);
        chk("t6_next_first", 32'(m_first), 32'd1);
        step();
        valid_in = 1'b0;
        drain();
        e6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        chk_log("t6", start, e6);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
